omr_sheet_scanner: RTL

OMR_SHEET_SCANNER -- requirements
Module: omr_sheet_scanner

---
 rtl/omr_sheet_scanner_if.sv | 29 ++
 rtl/omr_sheet_scanner.sv | 98 +++++++++
 2 files changed

// File: rtl/omr_sheet_scanner_if.sv
// Row intake and held-sheet handoff bundle for omr_sheet_scanner.
// Rows use valid/ready. The held sheet stays valid until sheet_ready is seen.
interface omr_sheet_scanner_if #(
  parameter int NUM_Q = 10,
  parameter int OPT_W = 4
);
  localparam int CNT_W = $clog2(NUM_Q + 1);

  logic [OPT_W-1:0]       row_bits;
  logic                   row_sof;
  logic                   row_valid;
  logic                   row_ready;
  logic [NUM_Q*OPT_W-1:0] answers;
  logic [CNT_W-1:0]       blank_cnt;
  logic [CNT_W-1:0]       multi_cnt;
  logic [7:0]             sheet_id;
  logic                   sheet_valid;
  logic                   sheet_ready;

  modport master (
    output row_bits, row_sof, row_valid, sheet_ready,
    input  row_ready, answers, blank_cnt, multi_cnt, sheet_id, sheet_valid
  );

  modport slave (
    input  row_bits, row_sof, row_valid, sheet_ready,
    output row_ready, answers, blank_cnt, multi_cnt, sheet_id, sheet_valid
  );
endinterface

// File: rtl/omr_sheet_scanner.sv
// Assembles OMR bubble rows into a one-hot answer word. sheet_valid rises 1 cycle after the last row.
// row_ready drops while a sheet is held. Define OMR_INVALID_ROW_CLEAR_EN to store blank/multi rows as 0.
module omr_sheet_scanner #(
  parameter int NUM_Q = 10,
  parameter int OPT_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  omr_sheet_scanner_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_Q + 1);
  localparam int ANS_W = NUM_Q * OPT_W;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] idx_q, idx_d, slot;
  logic [CNT_W-1:0] blank_q, blank_d, multi_q, multi_d;
  logic [ANS_W-1:0] answers_q, answers_d;
  logic [7:0]       id_q;
  logic             valid_q, rdy_q;
  logic             accept, first_row, row_blank, row_multi, last_row;
  logic [OPT_W-1:0] row_store;

  // rdy_q resets to 1 so intake is open on the first cycle after reset;
  // gating with reset_n keeps row_ready low while reset is held.
  assign bus.row_ready = rdy_q & reset_n;
  assign accept        = bus.row_valid & bus.row_ready;
  assign first_row     = (state_q == IDLE) | bus.row_sof;
  assign row_blank     = (bus.row_bits == '0);
  assign row_multi     = ((bus.row_bits & (bus.row_bits - OPT_W'(1))) != '0);

`ifdef OMR_INVALID_ROW_CLEAR_EN
  assign row_store = (row_blank | row_multi) ? '0 : bus.row_bits;
`else
  assign row_store = bus.row_bits;
`endif

  always_comb begin
    slot      = first_row ? '0 : idx_q;
    idx_d     = slot + CNT_W'(1);
    last_row  = (slot == CNT_W'(NUM_Q - 1));
    answers_d = first_row ? '0 : answers_q;
    answers_d[OPT_W*(NUM_Q-int'(slot))-1 -: OPT_W] = row_store;
    blank_d   = (first_row ? '0 : blank_q) + CNT_W'(row_blank);
    multi_d   = (first_row ? '0 : multi_q) + CNT_W'(row_multi);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      answers_q <= '0;
      blank_q   <= '0;
      multi_q   <= '0;
      id_q      <= '0;
      valid_q   <= 1'b0;
      rdy_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE, SCAN: begin
          if (accept) begin
            answers_q <= answers_d;
            blank_q   <= blank_d;
            multi_q   <= multi_d;
            if (last_row) begin
              state_q <= HOLD;
              idx_q   <= '0;
              valid_q <= 1'b1;
              rdy_q   <= 1'b0;
            end else begin
              state_q <= SCAN;
              idx_q   <= idx_d;
            end
          end
        end
        HOLD: begin
          if (bus.sheet_ready) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            rdy_q     <= 1'b1;
            id_q      <= id_q + 8'd1;
            answers_q <= '0;
            blank_q   <= '0;
            multi_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.answers     = answers_q;
  assign bus.blank_cnt   = blank_q;
  assign bus.multi_cnt   = multi_q;
  assign bus.sheet_id    = id_q;
  assign bus.sheet_valid = valid_q;
endmodule
